// File: rtl/sequence_serializer_if.sv
// Byte-sequence input port and byte-stream output port of the sequence serializer.
// slave is the serializer's view of the bus; master is the view of the logic around it.
interface sequence_serializer_if #(
  parameter int MAX_BYTES   = 4,
  parameter int COUNT_WIDTH = 3
);
  logic [COUNT_WIDTH+8*MAX_BYTES-1:0] in_sequence;
  logic                               in_sequence_available;
  logic                               in_sequence_ready;
  logic                               receiver_ready;
  logic [7:0]                         out_data;
  logic                               out_data_available;
  logic                               out_last;
  logic                               busy;

  modport master (
    output in_sequence, in_sequence_available, receiver_ready,
    input  in_sequence_ready, out_data, out_data_available, out_last, busy
  );

  modport slave (
    input  in_sequence, in_sequence_available, receiver_ready,
    output in_sequence_ready, out_data, out_data_available, out_last, busy
  );
endinterface

// File: rtl/sequence_serializer.sv
// Buffers variable-length byte sequences in a small FIFO and emits them one byte per clock.
// Optional flush input is enabled by defining SEQUENCE_SERIALIZER_FLUSH_EN.
//
// state  | meaning
// S_IDLE | no byte pending on the output
// S_EMIT | out_data valid; remain_q bytes of this sequence still follow
module sequence_serializer #(
  parameter int MAX_BYTES   = 4,
  parameter int COUNT_WIDTH = 3,
  parameter int FIFO_DEPTH  = 2,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef SEQUENCE_SERIALIZER_FLUSH_EN
  input  logic                  flush,
`endif
  sequence_serializer_if.slave  bus
);
  localparam int DW     = 8 * MAX_BYTES;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_BYTES);
  localparam logic [COUNT_WIDTH-1:0] ONE_CNT = COUNT_WIDTH'(1);
  localparam logic [FILL_W-1:0]      DEPTH_F = FILL_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_EMIT} state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_mem [FIFO_DEPTH];
  logic [DW-1:0]          dat_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [DW-1:0]          shreg_q, shreg_d;
  logic [COUNT_WIDTH-1:0] remain_q, remain_d;
  logic [7:0]             data_q, data_d;
  logic                   last_q, last_d;

  logic                   flush_w;
  logic                   full, empty, push, pop, load;
  logic [COUNT_WIDTH-1:0] in_cnt, in_cnt_clamped, head_cnt;
  logic [DW-1:0]          in_dat, head_dat, aligned;
  logic [7:0]             first_byte, next_byte;

`ifdef SEQUENCE_SERIALIZER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_cnt         = bus.in_sequence[COUNT_WIDTH+DW-1 -: COUNT_WIDTH];
  assign in_dat         = bus.in_sequence[DW-1:0];
  assign in_cnt_clamped = (in_cnt > MAX_CNT) ? MAX_CNT : in_cnt;

  assign full  = (fill_q == DEPTH_F);
  assign empty = (fill_q == '0);
  assign bus.in_sequence_ready = !full && !reset && !flush_w;
  // zero-length sequences complete the handshake but never occupy an entry
  assign push = bus.in_sequence_available && bus.in_sequence_ready && (in_cnt != '0);

  assign head_cnt = cnt_mem[rd_ptr_q];
  assign head_dat = dat_mem[rd_ptr_q];

  // MSB-first left-aligns the valid range so every byte leaves from the top of the shifter
  always_comb begin
    if (LSB_FIRST) begin
      aligned    = head_dat;
      first_byte = aligned[7:0];
      next_byte  = shreg_q[7:0];
    end else begin
      aligned    = head_dat << (8 * (MAX_BYTES - int'(head_cnt)));
      first_byte = aligned[DW-1 -: 8];
      next_byte  = shreg_q[DW-1 -: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    remain_d = remain_q;
    data_d   = data_q;
    last_d   = last_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE: load = !empty;
      S_EMIT: begin
        if (bus.receiver_ready) begin
          if (remain_q != '0) begin
            data_d   = next_byte;
            shreg_d  = LSB_FIRST ? (shreg_q >> 8) : (shreg_q << 8);
            remain_d = remain_q - ONE_CNT;
            last_d   = (remain_q == ONE_CNT);
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            data_d  = '0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d  = S_EMIT;
      data_d   = first_byte;
      shreg_d  = LSB_FIRST ? (aligned >> 8) : (aligned << 8);
      remain_d = head_cnt - ONE_CNT;
      last_d   = (head_cnt == ONE_CNT);
    end
  end

  assign pop = load;

  always_comb begin
    fill_d = fill_q;
    if (push && !pop)      fill_d = fill_q + FILL_W'(1);
    else if (pop && !push) fill_d = fill_q - FILL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cnt_mem[wr_ptr_q] <= in_cnt_clamped;
      dat_mem[wr_ptr_q] <= in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_w) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      shreg_q  <= '0;
      remain_q <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      shreg_q  <= shreg_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      last_q   <= last_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign bus.out_data           = data_q;
  assign bus.out_data_available = (state_q == S_EMIT);
  assign bus.out_last           = last_q;
  assign bus.busy               = !empty || (state_q == S_EMIT);
endmodule

// File: tb/tb_sequence_serializer.sv
// Randomized and directed bench for sequence_serializer: an MSB-first and an LSB-first
// instance share stimulus and are both compared against a queue-of-sequences model.
module tb_sequence_serializer;
  localparam int MB    = 4;
  localparam int CW    = 3;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] data;
    int          n;
    int          acc;
  } seq_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_s;
  logic          in_av;
  logic [34:0]   in_seq;
  logic          rr_s;

  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  bit   cur_rst;
  bit   cur_fl;
  seq_t q[$];
  int   pos = 0;

  sequence_serializer_if #(.MAX_BYTES(MB), .COUNT_WIDTH(CW)) bus0 ();
  sequence_serializer_if #(.MAX_BYTES(MB), .COUNT_WIDTH(CW)) bus1 ();

  assign bus0.in_sequence           = in_seq;
  assign bus0.in_sequence_available = in_av;
  assign bus0.receiver_ready        = rr_s;
  assign bus1.in_sequence           = in_seq;
  assign bus1.in_sequence_available = in_av;
  assign bus1.receiver_ready        = rr_s;

  sequence_serializer #(.MAX_BYTES(MB), .COUNT_WIDTH(CW), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b0)) dut_msb (
    .clk   (clk),
    .reset (reset),
`ifdef SEQUENCE_SERIALIZER_FLUSH_EN
    .flush (flush_s),
`endif
    .bus   (bus0)
  );

  sequence_serializer #(.MAX_BYTES(MB), .COUNT_WIDTH(CW), .FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut_lsb (
    .clk   (clk),
    .reset (reset),
`ifdef SEQUENCE_SERIALIZER_FLUSH_EN
    .flush (flush_s),
`endif
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, ncyc, got, exp);
    end
  endtask

  // the head sequence is on the output once a full edge has passed since it was accepted
  function automatic bit presented();
    return (q.size() != 0) && (q[0].acc < ncyc);
  endfunction

  function automatic int occupancy();
    return q.size() - (presented() ? 1 : 0);
  endfunction

  function automatic logic [7:0] exp_byte(input seq_t s, input int p, input bit lsb);
    int k;
    k = lsb ? p : (s.n - 1 - p);
    return 8'(s.data >> (8 * k));
  endfunction

  task automatic check_outputs();
    bit p;
    p = presented();
    chk("valid",     32'(bus0.out_data_available), 32'(p));
    chk("valid_lsb", 32'(bus1.out_data_available), 32'(p));
    chk("busy",      32'(bus0.busy), 32'(q.size() != 0));
    chk("ready",     32'(bus0.in_sequence_ready),
        32'(!cur_rst && !cur_fl && (occupancy() < DEPTH)));
    if (p) begin
      chk("data",     32'(bus0.out_data), 32'(exp_byte(q[0], pos, 1'b0)));
      chk("data_lsb", 32'(bus1.out_data), 32'(exp_byte(q[0], pos, 1'b1)));
      chk("last",     32'(bus0.out_last), 32'(pos == q[0].n - 1));
      chk("last_lsb", 32'(bus1.out_last), 32'(pos == q[0].n - 1));
    end else begin
      chk("last_idle", 32'(bus0.out_last), 32'(0));
    end
  endtask

  task automatic cycle(input bit rst, input bit fl, input bit av,
                       input logic [2:0] cnt, input logic [31:0] dat, input bit rr);
    bit acc, xfer;
    seq_t s;
    reset   = rst;
    flush_s = fl;
    in_av   = av;
    in_seq  = {cnt, dat};
    rr_s    = rr;
    acc  = av && !rst && !fl && (occupancy() < DEPTH);
    xfer = !rst && !fl && presented() && rr;
    @(posedge clk);
    ncyc++;
    #1;
    if (rst || fl) begin
      q.delete();
      pos = 0;
    end else begin
      if (xfer) begin
        pos++;
        if (pos == q[0].n) begin
          void'(q.pop_front());
          pos = 0;
        end
      end
      if (acc && cnt != 3'd0) begin
        s.data = dat;
        s.n    = (int'(cnt) > MB) ? MB : int'(cnt);
        s.acc  = ncyc;
        q.push_back(s);
      end
    end
    cur_rst = rst;
    cur_fl  = fl;
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, rr);
  endtask

  initial begin
    reset = 1'b1; flush_s = 1'b0; in_av = 1'b0; in_seq = '0; rr_s = 1'b0;
    cur_rst = 1'b1; cur_fl = 1'b0;

    cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
    chk("rst_data", 32'(bus0.out_data), 32'(0));
    idle(1, 1'b1);

    // legacy 4-byte order
    cycle(1'b0, 1'b0, 1'b1, 3'd4, 32'h1B5B3241, 1'b1);
    idle(6, 1'b1);

    // back-to-back sequences, no bubble
    cycle(1'b0, 1'b0, 1'b1, 3'd2, 32'h00004142, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 3'd1, 32'h0000000D, 1'b1);
    idle(5, 1'b1);

    // downstream stall fills the FIFO
    cycle(1'b0, 1'b0, 1'b1, 3'd4, 32'hC1C2C3C4, 1'b1);
    idle(2, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 3'(2 + (i % 2)), 32'hD0D1D2D3 + 32'(i), 1'b0);
    idle(14, 1'b1);

    // zero length and clamped length
    cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'hDEADBEEF, 1'b1);
    idle(3, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 3'd7, 32'hE1E2E3E4, 1'b1);
    idle(7, 1'b1);

    cycle(1'b0, 1'b0, 1'b1, 3'd3, 32'h00112233, 1'b1);
    idle(5, 1'b1);

    // reset after the second byte with one entry still buffered
    cycle(1'b0, 1'b0, 1'b1, 3'd4, 32'hA1A2A3A4, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 3'd2, 32'h0000B1B2, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1);
    chk("midrst_data", 32'(bus0.out_data), 32'(0));
    idle(6, 1'b1);

`ifdef SEQUENCE_SERIALIZER_FLUSH_EN
    cycle(1'b0, 1'b0, 1'b1, 3'd4, 32'hF1F2F3F4, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 3'd2, 32'h0000F5F6, 1'b1);
    idle(2, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 3'd3, 32'h00777777, 1'b1);
    chk("flush_data", 32'(bus0.out_data), 32'(0));
    idle(6, 1'b1);
`endif

    for (int i = 0; i < 600; i++) begin
      bit rst, fl;
      rst = ($urandom_range(0, 99) == 0);
      fl  = 1'b0;
`ifdef SEQUENCE_SERIALIZER_FLUSH_EN
      fl  = ($urandom_range(0, 99) == 0);
`endif
      cycle(rst, fl, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 9) < 7));
    end
    idle(20, 1'b1);
    chk("drained", 32'(bus0.busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
